tdl_mc_fifo: RTL and testbench

Multi-channel, BRAM-backed FIFO for `TaggedDirection_len` records, parametrised in field width, tag width, depth and channel count. Each of CHANNELS producers (ray-generation lanes) writes into its own circular buffer; a round-robin arbiter drains all channels through one valid/ready output port toward the intersection pipeline. Adds a back-pressured output, per-channel occupancy, almost-full, sticky overflow and synchronous flush.

---
 rtl/tdl_mc_fifo_if.sv | 53 +++++
 rtl/tdl_mc_fifo.sv | 248 ++++++++++++++++++++++++
 tb/tb_tdl_mc_fifo.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tdl_mc_fifo_if.sv
// -----------------------------------------------------------------------------
// tdl_mc_fifo_if
// Handshake bundle for the multi-channel TaggedDirection_len FIFO.
//
// A record is packed as {dir_x, dir_y, dir_z, len, tag}. The tag sits in the
// low TAG_SIZE bits, and each of the four WIDTH-bit fields sits above it.
//
// Signals
//   in_valid  [CHANNELS]      per-channel write request          (producer -> fifo)
//   in_tdl    [CHANNELS]      per-channel write record           (producer -> fifo)
//   in_ready  [CHANNELS]      channel can take a record          (fifo -> producer)
//   out_valid                 out_tdl/out_ch hold a record       (fifo -> consumer)
//   out_ready                 consumer takes the record          (consumer -> fifo)
//   out_tdl                   head record of the granted channel (fifo -> consumer)
//   out_ch                    source channel of out_tdl          (fifo -> consumer)
//
// Modports
//   master : producers/consumer side (testbench or surrounding pipeline)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 48
`endif

interface tdl_mc_fifo_if #(
  parameter int WIDTH    = `WIDTH,
  parameter int TAG_SIZE = `TAG_SIZE,
  parameter int CHANNELS = 4
);
  localparam int REC_W = 4 * WIDTH + TAG_SIZE;
  localparam int CH_W  = $clog2(CHANNELS);

  logic [CHANNELS-1:0] in_valid;
  logic [REC_W-1:0]    in_tdl [CHANNELS];
  logic [CHANNELS-1:0] in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [REC_W-1:0]    out_tdl;
  logic [CH_W-1:0]     out_ch;

  modport master (
    output in_valid, in_tdl, out_ready,
    input  in_ready, out_valid, out_tdl, out_ch
  );

  modport slave (
    input  in_valid, in_tdl, out_ready,
    output in_ready, out_valid, out_tdl, out_ch
  );
endinterface

// File: rtl/tdl_mc_fifo.sv
// -----------------------------------------------------------------------------
// tdl_mc_fifo
// Multi-channel block-RAM FIFO for TaggedDirection_len records. Each producer
// lane owns a circular buffer. A round-robin arbiter drains all lanes through
// one valid/ready port toward the intersection pipeline.
//
// Parameters
//   WIDTH      width of each of dir_x/dir_y/dir_z/len
//   TAG_SIZE   tag width
//   DEPTH      entries per channel (power of two, >= 2)
//   CHANNELS   number of producer lanes (>= 2)
//   AF_THRESH  almost_full asserts when count >= AF_THRESH
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   bus          handshake bundle (tdl_mc_fifo_if.slave)
//   count        per-channel occupancy
//   almost_full  per-channel count >= AF_THRESH
//   overflow     per-channel sticky "write attempted while full"
//   clear_ovf    synchronous clear of all overflow bits
//   flush        synchronous empty of all channels
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 48
`endif

module tdl_mc_fifo #(
  parameter int WIDTH     = `WIDTH,
  parameter int TAG_SIZE  = `TAG_SIZE,
  parameter int DEPTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int AF_THRESH = DEPTH - 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  tdl_mc_fifo_if.slave                 bus,
  output logic [$clog2(DEPTH+1)-1:0]   count [CHANNELS],
  output logic [CHANNELS-1:0]          almost_full,
  output logic [CHANNELS-1:0]          overflow,
  input  logic                         clear_ovf,
  input  logic                         flush
);

  localparam int REC_W = 4 * WIDTH + TAG_SIZE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CH_W  = $clog2(CHANNELS);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(AF_THRESH);
  localparam logic [CH_W-1:0]  LAST_INIT = CH_W'(CHANNELS - 1);

  // Per-channel state
  logic [CHANNELS-1:0][PTR_W-1:0] wptr_q, wptr_d;
  logic [CHANNELS-1:0][PTR_W-1:0] rptr_q, rptr_d;
  logic [CHANNELS-1:0][CNT_W-1:0] count_q, count_d;
  logic [CHANNELS-1:0]            in_ready_q, in_ready_d;
  logic [CHANNELS-1:0]            af_q, af_d;
  logic [CHANNELS-1:0]            ovf_q, ovf_d;

  // Output-side state
  logic                           out_valid_q, out_valid_d;
  logic [CH_W-1:0]                out_ch_q, out_ch_d;
  logic [CH_W-1:0]                last_ch_q, last_ch_d;

  // Combinational controls
  logic [CHANNELS-1:0]            wr_en_s;
  logic [CHANNELS-1:0]            ovf_set_s;
  logic [CHANNELS-1:0]            rd_en_s;
  logic [CH_W-1:0]                grant_s;
  logic                           grant_vld_s;
  logic                           issue_s;
  logic [CHANNELS-1:0][REC_W-1:0] rd_data_s;

  // ---------------------------------------------------------------------------
  // Storage: one memory per channel with its own registered read port. A read
  // is launched only when that channel is granted. The read register therefore
  // keeps the issued record until the next issue from the same channel, and
  // out_tdl can be taken from the register selected by out_ch.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    (* ram_style = "block" *) logic [REC_W-1:0] mem_q [DEPTH];
    logic [REC_W-1:0] rd_q;

    // Channel write port
    always_ff @(posedge clk) begin
      if (wr_en_s[c]) begin
        mem_q[wptr_q[c]] <= bus.in_tdl[c];
      end
    end

    // Channel registered read port, fired on grant
    always_ff @(posedge clk) begin
      if (rd_en_s[c]) begin
        rd_q <= mem_q[rptr_q[c]];
      end
    end

    assign rd_data_s[c] = rd_q;
  end

  // Write acceptance and overflow detection. Flush drops writes silently.
  always_comb begin
    wr_en_s   = '0;
    ovf_set_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (flush) begin
        wr_en_s[c]   = 1'b0;
        ovf_set_s[c] = 1'b0;
      end else begin
        wr_en_s[c]   = bus.in_valid[c] &  in_ready_q[c];
        ovf_set_s[c] = bus.in_valid[c] & ~in_ready_q[c];
      end
    end
  end

  // Round-robin search. Start just after last_ch and take the first nonempty channel.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      logic [CH_W-1:0] idx;
      idx = CH_W'((int'(last_ch_q) + i) % CHANNELS);
      if (!grant_vld_s && (count_q[idx] != '0)) begin
        grant_vld_s = 1'b1;
        grant_s     = idx;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Issue when the output slot is free or drains this cycle. out_ready reaches
  // the issue decision through this single gate only.
  always_comb begin
    issue_s = grant_vld_s & (~out_valid_q | bus.out_ready) & ~flush;
    rd_en_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (issue_s && (grant_s == CH_W'(c))) begin
        rd_en_s[c] = 1'b1;
      end else begin
        rd_en_s[c] = 1'b0;
      end
    end
  end

  // Per-channel pointer, occupancy and status next-state.
  // in_ready and almost_full are registered from the next count.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    in_ready_d = in_ready_q;
    af_d       = af_q;
    ovf_d      = ovf_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (flush) begin
        wptr_d[c]  = '0;
        rptr_d[c]  = '0;
        count_d[c] = '0;
      end else begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (wr_en_s[c]) begin
          wptr_d[c] = wptr_q[c] + PTR_W'(1);
        end else begin
          wptr_d[c] = wptr_q[c];
        end
        if (rd_en_s[c]) begin
          rptr_d[c] = rptr_q[c] + PTR_W'(1);
        end else begin
          rptr_d[c] = rptr_q[c];
        end
        case ({wr_en_s[c], rd_en_s[c]})
          2'b10:   count_d[c] = count_q[c] + CNT_W'(1);
          2'b01:   count_d[c] = count_q[c] - CNT_W'(1);
          default: count_d[c] = count_q[c];
        endcase
      end
      in_ready_d[c] = (count_d[c] != CNT_FULL);
      af_d[c]       = (count_d[c] >= CNT_AF);
      // A new overflow wins over a same-cycle clear.
      ovf_d[c]      = ovf_set_s[c] | (ovf_q[c] & ~clear_ovf);
    end
  end

  // Output slot and arbitration-pointer next-state
  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    last_ch_d   = last_ch_q;
    if (flush) begin
      out_valid_d = 1'b0;
      last_ch_d   = LAST_INIT;
    end else if (issue_s) begin
      out_valid_d = 1'b1;
      out_ch_d    = grant_s;
      last_ch_d   = grant_s;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= {CHANNELS{1'b1}};
      af_q        <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      last_ch_q   <= LAST_INIT;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      af_q        <= af_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      last_ch_q   <= last_ch_d;
    end
  end

  // Drive outputs from registers
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      count[c] = count_q[c];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_tdl   = rd_data_s[out_ch_q];
  assign almost_full   = af_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_tdl_mc_fifo.sv
// -----------------------------------------------------------------------------
// tb_tdl_mc_fifo
// Directed self-checking bench for tdl_mc_fifo (WIDTH=16, TAG_SIZE=48,
// DEPTH=32, CHANNELS=4, AF_THRESH=28).
// -----------------------------------------------------------------------------
module tb_tdl_mc_fifo;

  localparam int W   = 16;
  localparam int T   = 48;
  localparam int D   = 32;
  localparam int CH  = 4;
  localparam int RW  = 4 * W + T;
  localparam int CW  = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] count_s [CH];
  logic [CH-1:0] almost_full_s;
  logic [CH-1:0] overflow_s;
  logic          clear_ovf;
  logic          flush;

  int errs   = 0;
  int checks = 0;

  tdl_mc_fifo_if #(.WIDTH(W), .TAG_SIZE(T), .CHANNELS(CH)) bus ();

  tdl_mc_fifo #(
    .WIDTH(W), .TAG_SIZE(T), .DEPTH(D), .CHANNELS(CH), .AF_THRESH(D - 4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .count      (count_s),
    .almost_full(almost_full_s),
    .overflow   (overflow_s),
    .clear_ovf  (clear_ovf),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  // Record built from a tag: {x, y, z, len, tag}
  function automatic logic [RW-1:0] rec(input int t);
    rec = {16'(t + 1), 16'(t + 2), 16'(t + 3), 16'(2 * t), 48'(t)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    clear_ovf     = 1'b0;
    flush         = 1'b0;
    for (int c = 0; c < CH; c++) bus.in_tdl[c] = '0;
    repeat (3) tick();

    // ---- reset state ----
    check("rst_valid", bus.out_valid, 0);
    check("rst_ready", bus.in_ready, 4'hF);
    check("rst_ovf", overflow_s, 0);
    check("rst_af", almost_full_s, 0);
    check("rst_cnt2", count_s[2], 0);
    reset_n = 1'b1;
    tick();

    // ---- single channel: 33 writes into ch2 fill it to 32 ----
    bus.in_valid = 4'b0100;
    for (int k = 1; k <= 33; k++) begin
      bus.in_tdl[2] = rec(k);
      tick();
      if (k == 1) begin
        check("sc_cnt_first", count_s[2], 1);
        check("sc_valid_t1", bus.out_valid, 0);
      end
      if (k == 2) begin
        check("sc_valid_t2", bus.out_valid, 1);
        check("sc_first_tdl", bus.out_tdl, rec(1));
        check("sc_first_ch", bus.out_ch, 2);
      end
      if (k == 28) check("sc_af_27", almost_full_s[2], 0);
      if (k == 29) check("sc_af_28", almost_full_s[2], 1);
    end
    check("sc_cnt_full", count_s[2], 32);
    check("sc_ready_full", bus.in_ready, 4'b1011);
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    for (int k = 2; k <= 33; k++) begin
      tick();
      check("sc_seq_tdl", bus.out_tdl, rec(k));
      check("sc_seq_ch", bus.out_ch, 2);
    end
    tick();
    check("sc_drained_valid", bus.out_valid, 0);
    check("sc_drained_cnt", count_s[2], 0);
    check("sc_drained_ready", bus.in_ready, 4'hF);

    // ---- overflow on ch1 ----
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0010;
    for (int k = 1; k <= 33; k++) begin
      bus.in_tdl[1] = rec(100 + k);
      tick();
    end
    check("ov_cnt_full", count_s[1], 32);
    bus.in_tdl[1] = rec(99);
    tick();
    check("ov_set", overflow_s, 4'b0010);
    check("ov_cnt_hold", count_s[1], 32);
    bus.in_valid = '0;
    tick();
    check("ov_sticky", overflow_s, 4'b0010);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ov_cleared", overflow_s, 0);
    bus.in_valid = 4'b0010;
    clear_ovf    = 1'b1;
    tick();
    check("ov_set_wins", overflow_s, 4'b0010);
    bus.in_valid = '0;
    tick();
    clear_ovf = 1'b0;
    check("ov_cleared2", overflow_s, 0);
    check("ov_head_stable", bus.out_tdl, rec(101));
    bus.out_ready = 1'b1;
    for (int k = 2; k <= 33; k++) begin
      tick();
      check("ov_seq_tdl", bus.out_tdl, rec(100 + k));
    end
    tick();
    check("ov_drained", bus.out_valid, 0);

    // ---- reset mid-stream ----
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1010;
    bus.in_tdl[3] = rec(7);
    bus.in_tdl[1] = rec(8);
    tick();
    bus.in_valid = '0;
    tick();
    check("rr_after_ch1", bus.out_ch, 3);
    check("mid_valid", bus.out_valid, 1);
    reset_n = 1'b0;
    tick();
    check("mrst_valid", bus.out_valid, 0);
    check("mrst_cnt1", count_s[1], 0);
    check("mrst_cnt3", count_s[3], 0);
    check("mrst_ready", bus.in_ready, 4'hF);
    check("mrst_ovf", overflow_s, 0);
    check("mrst_ch", bus.out_ch, 0);
    reset_n = 1'b1;
    tick();

    // ---- round robin with back-pressure ----
    bus.in_valid  = 4'b1011;
    bus.in_tdl[0] = rec(200);
    bus.in_tdl[1] = rec(201);
    bus.in_tdl[3] = rec(203);
    tick();
    bus.in_valid  = 4'b1001;
    bus.in_tdl[0] = rec(210);
    bus.in_tdl[3] = rec(213);
    tick();
    bus.in_valid = '0;
    check("rr_a0", bus.out_tdl, rec(200));
    check("rr_a0_ch", bus.out_ch, 0);
    bus.out_ready = 1'b1;
    tick();
    check("rr_b0", bus.out_tdl, rec(201));
    check("rr_b0_ch", bus.out_ch, 1);
    tick();
    check("rr_d0", bus.out_tdl, rec(203));
    check("rr_d0_ch", bus.out_ch, 3);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_tdl", bus.out_tdl, rec(203));
      check("bp_ch", bus.out_ch, 3);
      check("bp_cnt0", count_s[0], 1);
      check("bp_cnt3", count_s[3], 1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("rr_a1", bus.out_tdl, rec(210));
    check("rr_a1_ch", bus.out_ch, 0);
    tick();
    check("rr_d1", bus.out_tdl, rec(213));
    check("rr_d1_ch", bus.out_ch, 3);
    tick();
    check("rr_done", bus.out_valid, 0);

    // ---- continuous write+drain on ch3, pointers wrap ----
    bus.in_valid = 4'b1000;
    for (int i = 0; i < 100; i++) begin
      bus.in_tdl[3] = rec(1000 + i);
      tick();
      if (i >= 1) begin
        check("wr_tdl", bus.out_tdl, rec(1000 + i - 1));
        check("wr_cnt", count_s[3], 1);
      end
    end
    bus.in_valid = '0;
    tick();
    check("wr_last", bus.out_tdl, rec(1099));
    check("wr_last_cnt", count_s[3], 0);
    tick();
    check("wr_done", bus.out_valid, 0);

    // ---- flush with in_valid high, overflow preserved ----
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0010;
    for (int k = 1; k <= 34; k++) begin
      bus.in_tdl[1] = rec(300 + k);
      tick();
    end
    check("fl_pre_ovf", overflow_s, 4'b0010);
    check("fl_pre_valid", bus.out_valid, 1);
    bus.in_valid = 4'b1111;
    for (int c = 0; c < CH; c++) bus.in_tdl[c] = rec(400 + c);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < CH; c++) bus.in_tdl[c] = rec(500 + c);
    check("fl_valid", bus.out_valid, 0);
    check("fl_cnt0", count_s[0], 0);
    check("fl_cnt1", count_s[1], 0);
    check("fl_cnt3", count_s[3], 0);
    check("fl_ovf", overflow_s, 4'b0010);
    check("fl_ready", bus.in_ready, 4'hF);
    tick();
    bus.in_valid = '0;
    check("fl_post_cnt0", count_s[0], 1);
    check("fl_post_cnt1", count_s[1], 1);
    tick();
    check("fl_grant_ch", bus.out_ch, 0);
    check("fl_grant_tdl", bus.out_tdl, rec(500));
    check("fl_ovf_kept", overflow_s, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
